// File: rtl/ram_bist.sv
// March-style BIST initiator for a single-port RAM: W(P) ^ R(P)W(~P) v R(~P)W(P) ^ R(P).
// Drives the RAM port while busy and records the error count plus first-failure diagnostics.
module ram_bist #(
    parameter int                 ADDR_W  = 10,
    parameter int                 DATA_W  = 8,
    parameter logic [DATA_W-1:0]  PATTERN = 8'h55
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_start,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_fail,
    output logic [ADDR_W+1:0]   o_err_count,
    output logic [ADDR_W-1:0]   o_first_err_addr,
    output logic [DATA_W-1:0]   o_first_err_data,
    output logic                o_ram_wr,
    output logic                o_ram_rd,
    output logic [ADDR_W-1:0]   o_ram_address,
    output logic [DATA_W-1:0]   o_ram_datain,
    input  logic [DATA_W-1:0]   i_ram_out
);

    typedef enum logic [2:0] {
        S_IDLE, S_M1_W, S_M2_R, S_M2_W, S_M3_R, S_M3_W, S_M4_R, S_DONE
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_busy, r_done, r_fail, r_wr, r_rd;
    logic [ADDR_W+1:0]   r_err_count;
    logic [ADDR_W-1:0]   r_first_err_addr;
    logic [DATA_W-1:0]   r_first_err_data, r_datain;

    state_t              w_next_state;
    logic [ADDR_W-1:0]   w_next_addr;
    logic                w_next_wr, w_next_rd, w_next_busy;
    logic [DATA_W-1:0]   w_next_datain, w_exp;
    logic                w_last, w_first, w_start_ok, w_rd_cycle, w_mismatch;

    assign w_last     = (r_addr == '1);
    assign w_first    = (r_addr == '0);
    assign w_start_ok = (r_state == S_IDLE) && i_start;

    always_comb begin
        w_next_state = r_state;
        w_next_addr  = r_addr;
        case (r_state)
            S_IDLE: if (i_start) begin
                w_next_state = S_M1_W;
                w_next_addr  = '0;
            end
            S_M1_W: begin
                w_next_state = w_last ? S_M2_R : S_M1_W;
                w_next_addr  = r_addr + ADDR_W'(1);
            end
            S_M2_R: w_next_state = S_M2_W;
            // The M2->M3 handoff keeps the top address: M3 starts where M2 ended.
            S_M2_W: begin
                w_next_state = w_last ? S_M3_R : S_M2_R;
                w_next_addr  = w_last ? r_addr : r_addr + ADDR_W'(1);
            end
            S_M3_R: w_next_state = S_M3_W;
            S_M3_W: begin
                w_next_state = w_first ? S_M4_R : S_M3_R;
                w_next_addr  = w_first ? '0 : r_addr - ADDR_W'(1);
            end
            S_M4_R: begin
                w_next_state = w_last ? S_DONE : S_M4_R;
                w_next_addr  = r_addr + ADDR_W'(1);
            end
            S_DONE: begin
                w_next_state = S_IDLE;
                w_next_addr  = '0;
            end
            default: begin
                w_next_state = S_IDLE;
                w_next_addr  = '0;
            end
        endcase
    end

    // Port controls are decoded from the next state so they are registered alongside it.
    always_comb begin
        w_next_wr     = 1'b0;
        w_next_rd     = 1'b0;
        w_next_datain = '0;
        case (w_next_state)
            S_M1_W, S_M3_W: begin w_next_wr = 1'b1; w_next_datain = PATTERN;  end
            S_M2_W:         begin w_next_wr = 1'b1; w_next_datain = ~PATTERN; end
            S_M2_R, S_M3_R, S_M4_R: w_next_rd = 1'b1;
            default: ;
        endcase
        w_next_busy = w_next_wr | w_next_rd;
    end

    assign w_rd_cycle = (r_state == S_M2_R) || (r_state == S_M3_R) || (r_state == S_M4_R);
    assign w_exp      = (r_state == S_M3_R) ? ~PATTERN : PATTERN;
    assign w_mismatch = w_rd_cycle && (i_ram_out != w_exp);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state          <= S_IDLE;
            r_addr           <= '0;
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
            r_wr             <= 1'b0;
            r_rd             <= 1'b0;
            r_datain         <= '0;
            r_fail           <= 1'b0;
            r_err_count      <= '0;
            r_first_err_addr <= '0;
            r_first_err_data <= '0;
        end else begin
            r_state  <= w_next_state;
            r_addr   <= w_next_addr;
            r_busy   <= w_next_busy;
            r_done   <= (w_next_state == S_DONE);
            r_wr     <= w_next_wr;
            r_rd     <= w_next_rd;
            r_datain <= w_next_datain;
            if (w_start_ok) begin
                r_fail           <= 1'b0;
                r_err_count      <= '0;
                r_first_err_addr <= '0;
                r_first_err_data <= '0;
            end else if (w_mismatch) begin
                r_err_count <= r_err_count + (ADDR_W+2)'(1);
                if (!r_fail) begin
                    r_fail           <= 1'b1;
                    r_first_err_addr <= r_addr;
                    r_first_err_data <= i_ram_out;
                end
            end
        end
    end

    assign o_busy           = r_busy;
    assign o_done           = r_done;
    assign o_fail           = r_fail;
    assign o_err_count      = r_err_count;
    assign o_first_err_addr = r_first_err_addr;
    assign o_first_err_data = r_first_err_data;
    assign o_ram_wr         = r_wr;
    assign o_ram_rd         = r_rd;
    assign o_ram_address    = r_addr;
    assign o_ram_datain     = r_datain;

endmodule

// File: tb/tb_ram_bist.sv
// Bench for ram_bist: behavioural 1024x8 RAM with injectable faults, table of full runs,
// plus directed sequences for reset, mid-run reset and back-to-back starts.
module tb_ram_bist;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int RUN    = 6 * DEPTH;

    logic              clk = 1'b0;
    logic              rst, start;
    logic              busy, done, fail, ram_wr, ram_rd;
    logic [ADDR_W+1:0] err_count;
    logic [ADDR_W-1:0] first_err_addr, ram_address;
    logic [DATA_W-1:0] first_err_data, ram_datain, ram_out;

    int n_cmp = 0;
    int n_bad = 0;
    int fault_mode = 0;   // 0 clean, 1 addr5 bit0 stuck-1, 2 addr bit9 tied 0
    bit both_seen = 0;
    bit rd_data_seen = 0;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] eaddr;

    always #5 clk = ~clk;

    ram_bist #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .PATTERN(8'h55)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start),
        .o_busy(busy), .o_done(done), .o_fail(fail), .o_err_count(err_count),
        .o_first_err_addr(first_err_addr), .o_first_err_data(first_err_data),
        .o_ram_wr(ram_wr), .o_ram_rd(ram_rd), .o_ram_address(ram_address),
        .o_ram_datain(ram_datain), .i_ram_out(ram_out)
    );

    always_comb begin
        eaddr = ram_address;
        if (fault_mode == 2) eaddr[9] = 1'b0;
        ram_out = mem[eaddr];
        if (fault_mode == 1 && ram_address == 10'd5) ram_out[0] = 1'b1;
    end

    always @(posedge clk) begin
        if (ram_wr) mem[eaddr] <= ram_datain;
        if (ram_wr && ram_rd) both_seen <= 1'b1;
        if (!ram_wr && ram_datain != '0) rd_data_seen <= 1'b1;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for done; returns edges elapsed since the caller's reference edge.
    task automatic wait_done(input int cyc0, input bit repulse, output int cyc);
        cyc = cyc0;
        while (!done && cyc < RUN + 50) begin
            tick();
            cyc++;
            start = repulse && (cyc == 100);
        end
        start = 1'b0;
    endtask

    typedef struct {
        string name;
        int    mode;
        bit    repulse;
        int    exp_fail;
        int    exp_cnt;
        int    exp_addr;
        int    exp_data;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int cyc;
        int gap;
        vecs[0] = '{"clean",    0, 1'b0, 0, 0,    0,   'h00};
        vecs[1] = '{"stuck5",   1, 1'b0, 1, 1,    5,   'hAB};
        vecs[2] = '{"alias9",   2, 1'b0, 1, 1024, 512, 'hAA};
        vecs[3] = '{"restart",  0, 1'b1, 0, 0,    0,   'h00};

        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        rst = 1'b1; start = 1'b0;
        tick(); tick();
        chk("reset_outputs", int'({busy, done, fail, err_count, first_err_addr, first_err_data,
                                   ram_wr, ram_rd, ram_address, ram_datain}), 0);
        rst = 1'b0;
        tick();

        for (int v = 0; v < 4; v++) begin
            fault_mode = vecs[v].mode;
            both_seen = 0; rd_data_seen = 0;
            start = 1'b1;
            tick();
            start = 1'b0;
            chk({vecs[v].name, "_first_cycle"},
                int'({busy, ram_wr, ram_rd, ram_address, ram_datain}), int'({3'b110, 10'd0, 8'h55}));
            wait_done(0, vecs[v].repulse, cyc);
            chk({vecs[v].name, "_done_latency"}, cyc, RUN);
            chk({vecs[v].name, "_busy_at_done"}, int'(busy), 0);
            chk({vecs[v].name, "_fail"}, int'(fail), vecs[v].exp_fail);
            chk({vecs[v].name, "_err_count"}, int'(err_count), vecs[v].exp_cnt);
            chk({vecs[v].name, "_first_addr"}, int'(first_err_addr), vecs[v].exp_addr);
            chk({vecs[v].name, "_first_data"}, int'(first_err_data), vecs[v].exp_data);
            chk({vecs[v].name, "_wr_rd_overlap"}, int'(both_seen), 0);
            chk({vecs[v].name, "_datain_idle_zero"}, int'(rd_data_seen), 0);
            tick();
            chk({vecs[v].name, "_done_pulse"}, int'(done), 0);
            chk({vecs[v].name, "_results_held"}, int'({fail, err_count}),
                int'({vecs[v].exp_fail[0], 12'(vecs[v].exp_cnt)}));
        end

        // Reset mid-run, during a faulty run that has already logged errors.
        fault_mode = 2;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 3000; c++) tick();
        chk("abort_errs_logged", int'(err_count != 0), 1);
        rst = 1'b1;
        tick();
        chk("abort_outputs_zero", int'({busy, done, fail, err_count, first_err_addr, first_err_data,
                                       ram_wr, ram_rd, ram_address, ram_datain}), 0);
        tick(); tick();
        chk("abort_no_access", int'({ram_wr, ram_rd, busy}), 0);
        rst = 1'b0;
        fault_mode = 0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(0, 1'b0, cyc);
        chk("post_abort_latency", cyc, RUN);
        chk("post_abort_results", int'({fail, err_count, first_err_addr, first_err_data}), 0);
        tick();

        // Back-to-back with start held high.
        start = 1'b1;
        tick();
        wait_done(0, 1'b0, cyc);
        start = 1'b1;
        chk("b2b_first_latency", cyc, RUN);
        gap = 0;
        while (!ram_wr && gap < 10) begin
            tick();
            gap++;
        end
        chk("b2b_restart_gap", gap, 2);
        start = 1'b0;
        chk("b2b_second_start", int'({busy, ram_address, ram_datain}), int'({1'b1, 10'd0, 8'h55}));
        wait_done(0, 1'b0, cyc);
        chk("b2b_second_latency", cyc, RUN);
        chk("b2b_results", int'({fail, err_count}), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ram_bist.md
# ram_bist

March-style built-in self-test initiator for the 1024x8 single-port RAM (`ram`). It drives the RAM's `wr`, `rd`, `address` and `datain` inputs, samples its `out` bus, and reports pass/fail with first-failure diagnostics. It sits between the top-level test control logic and the RAM port, and owns the port while a test is running.

## Interface
Parameters:
- `ADDR_W`, default 10: RAM address width; depth = 2^ADDR_W.
- `DATA_W`, default 8: RAM data width.
- `PATTERN`, default 8'h55: background pattern; its complement is `~PATTERN`.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `start`  in  1  begin a test; sampled only in IDLE.
- `busy`  out  1  high while the test owns the RAM port.
- `done`  out  1  one-cycle pulse when a test completes.
- `fail`  out  1  at least one mismatch in the last run; held until next start.
- `err_count`  out  ADDR_W+2  number of mismatching reads in the last run.
- `first_err_addr`  out  ADDR_W  address of the first mismatch.
- `first_err_data`  out  DATA_W  data actually read at the first mismatch.
- `ram_wr`  out  1  to RAM `wr`.
- `ram_rd`  out  1  to RAM `rd`.
- `ram_address`  out  ADDR_W  to RAM `address`.
- `ram_datain`  out  DATA_W  to RAM `datain`.
- `ram_out`  in  DATA_W  from RAM `out`; combinational read data, valid in the same cycle as `ram_rd`.

## Operation
- All outputs are registered. On reset, every output is 0 and the FSM is in IDLE.
- FSM states and their actions:
  - IDLE.
  - M1_W: ascending addresses; write PATTERN.
  - M2_R: ascending; read and expect PATTERN.
  - M2_W: ascending; write ~PATTERN.
  - M3_R: descending; read and expect ~PATTERN.
  - M3_W: descending; write PATTERN.
  - M4_R: ascending; read and expect PATTERN.
  - DONE.
- Transitions:
  - IDLE -> M1_W on `start`.
  - M1_W loops over addresses 0..DEPTH-1, then -> M2_R at address 0.
  - M2_R -> M2_W at the same address. M2_W -> M2_R at address+1, or -> M3_R at DEPTH-1 after address DEPTH-1.
  - M3_R/M3_W follow the same pattern, descending. After address 0, go to M4_R at address 0.
  - M4_R runs 0..DEPTH-1, then -> DONE.
  - DONE -> IDLE.
- Port rules:
  - Exactly one of `ram_wr`/`ram_rd` is high in every M* state; both are 0 in IDLE and DONE.
  - `ram_datain` carries the write value in write cycles and is 0 otherwise.
- Compare: in each read cycle, `ram_out` is sampled at the closing clock edge and compared with the expected value.
  - On mismatch, `err_count` increments.
  - If `fail` was 0, `fail` is set to 1 and `first_err_addr`/`first_err_data` capture the address and `ram_out`.
- Width: at most 3*DEPTH reads per run, so `err_count` (ADDR_W+2 bits) never overflows and needs no saturation.
- On `start` acceptance:
  - `fail`, `err_count`, `first_err_addr` and `first_err_data` clear to 0.
  - `busy` rises.
- Result outputs hold their values through DONE and IDLE until the next accepted `start`.
- Boundary conditions:
  - `start` while busy: ignored.
  - `start` held high continuously: a new run begins in the cycle after DONE returns to IDLE.
  - `rst` mid-run: next cycle is IDLE, all outputs are 0, and no further RAM access occurs. RAM contents are undefined.
  - Descending address wrap: 0 is the last M3 address; the address counter never wraps to DEPTH-1 within a phase.

## Timing
- Edge numbering: `start` is sampled high in IDLE at edge k.
- From edge k: `busy`=1, `ram_wr`=1, `ram_address`=0, `ram_datain`=PATTERN.
- M1 takes DEPTH cycles, M2 2*DEPTH, M3 2*DEPTH, M4 DEPTH.
- Total busy time is 6*DEPTH cycles (6144 at the defaults).
- Last M4 read is the cycle beginning at edge k+6*DEPTH-1.
- At edge k+6*DEPTH: DONE, `busy`=0, `done`=1, and results are final.
- At edge k+6*DEPTH+1: IDLE, `done`=0.
- A compare error updates the result registers at the edge that closes its read cycle.

## Test plan
- Fault-free behavioural RAM, `start` pulse:
  - Cycle after start: `ram_wr`=1, address 0, data 0x55.
  - Busy for exactly 6144 cycles; `done` pulses once.
  - `fail`=0, `err_count`=0.
  - `ram_wr`&`ram_rd` never both 1.
- RAM model with bit 0 of address 5 stuck at 1:
  - `fail`=1, `err_count`=1, `first_err_addr`=5, `first_err_data`=0xAB (detected in M3).
- RAM model with address bit 9 tied 0, so 512..1023 alias 0..511:
  - `err_count`=1024, `first_err_addr`=512, `first_err_data`=0xAA.
- `start` re-pulsed at cycle 100 of a run:
  - Ignored; `done` still arrives at start+6144.
- `rst` asserted at cycle 3000 of a run, then `start`:
  - During reset, all outputs are 0.
  - The new run completes normally, with results cleared from the aborted run.
- Back-to-back runs with `start` held high, fault-free model:
  - Second run's first write occurs 2 cycles after the first `done`.
  - Results stay 0.
